// File: rtl/bless_xbar_st3.sv
// rtl/bless_xbar_st3.sv - BLESS router switch-traversal stage: registered 4x4 crossbar with deflection/error stats
//
// Optional port utilisation counters are enabled by defining BLESS_XBAR_PORT_STATS_EN.
//
// Ports:
//   clk, reset                  router clock, asynchronous active-high reset
//   flit_in_0..3, valid_in      per-channel flits and valid bits
//   apv_0..3, ppv_0..3          allocated / productive port vectors per channel
//   stat_clr                    synchronous clear of defl_cnt, alloc_err (and util_cnt_*)
//   flit_out_0..3, valid_out    registered crossbar outputs per network port
//   defl_cnt, alloc_err         saturating deflection count, sticky allocation-error flag
//   util_cnt_0..3               (optional) saturating per-port utilisation counts

module bless_xbar_st3 #(
    parameter int FLIT_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] flit_in_0,
    input  logic [FLIT_W-1:0] flit_in_1,
    input  logic [FLIT_W-1:0] flit_in_2,
    input  logic [FLIT_W-1:0] flit_in_3,
    input  logic [3:0]        valid_in,
    input  logic [3:0]        apv_0,
    input  logic [3:0]        apv_1,
    input  logic [3:0]        apv_2,
    input  logic [3:0]        apv_3,
    input  logic [3:0]        ppv_0,
    input  logic [3:0]        ppv_1,
    input  logic [3:0]        ppv_2,
    input  logic [3:0]        ppv_3,
    input  logic              stat_clr,
    output logic [FLIT_W-1:0] flit_out_0,
    output logic [FLIT_W-1:0] flit_out_1,
    output logic [FLIT_W-1:0] flit_out_2,
    output logic [FLIT_W-1:0] flit_out_3,
    output logic [3:0]        valid_out,
    output logic [CNT_W-1:0]  defl_cnt,
    output logic              alloc_err
`ifdef BLESS_XBAR_PORT_STATS_EN
    ,
    output logic [CNT_W-1:0]  util_cnt_0,
    output logic [CNT_W-1:0]  util_cnt_1,
    output logic [CNT_W-1:0]  util_cnt_2,
    output logic [CNT_W-1:0]  util_cnt_3
`endif
);

    logic [FLIT_W-1:0] fin      [4];
    logic [3:0]        apv      [4];
    logic [3:0]        ppv      [4];
    logic [FLIT_W-1:0] flit_q   [4];
    logic [FLIT_W-1:0] nxt_flit [4];
    logic [3:0]        nxt_valid;
    logic              err_evt;
    logic [2:0]        ndefl;
    logic [1:0]        tgt;
    logic [CNT_W:0]    defl_sum;
    logic [CNT_W-1:0]  defl_nxt;

    assign fin[0] = flit_in_0;
    assign fin[1] = flit_in_1;
    assign fin[2] = flit_in_2;
    assign fin[3] = flit_in_3;
    assign apv[0] = apv_0;
    assign apv[1] = apv_1;
    assign apv[2] = apv_2;
    assign apv[3] = apv_3;
    assign ppv[0] = ppv_0;
    assign ppv[1] = ppv_1;
    assign ppv[2] = ppv_2;
    assign ppv[3] = ppv_3;

    assign flit_out_0 = flit_q[0];
    assign flit_out_1 = flit_q[1];
    assign flit_out_2 = flit_q[2];
    assign flit_out_3 = flit_q[3];

    // Channels are visited in ascending order, so the first claimant of a port
    // is the lowest-index channel; later claimants are dropped and flagged.
    always_comb begin
        nxt_valid = '0;
        err_evt   = 1'b0;
        ndefl     = '0;
        tgt       = '0;
        for (int p = 0; p < 4; p++) begin
            nxt_flit[p] = '0;
        end
        for (int c = 0; c < 4; c++) begin
            if (valid_in[c]) begin
                if (apv[c] == 4'b0000) begin
                    err_evt = 1'b1;
                end else begin
                    // x & (x-1) clears the lowest set bit; non-zero means multi-hot
                    if ((apv[c] & (apv[c] - 4'd1)) != 4'b0000) begin
                        err_evt = 1'b1;
                    end
                    for (int b = 3; b >= 0; b--) begin
                        if (apv[c][b]) begin
                            tgt = b[1:0];
                        end
                    end
                    if (nxt_valid[tgt]) begin
                        err_evt = 1'b1;
                    end else begin
                        nxt_valid[tgt] = 1'b1;
                        nxt_flit[tgt]  = fin[c];
                    end
                    if ((apv[c] & ppv[c]) == 4'b0000) begin
                        ndefl = ndefl + 3'd1;
                    end
                end
            end
        end
    end

    // One extra bit of headroom so the carry out signals saturation
    assign defl_sum = {1'b0, defl_cnt} + {{(CNT_W-2){1'b0}}, ndefl};
    assign defl_nxt = defl_sum[CNT_W] ? {CNT_W{1'b1}} : defl_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= '0;
            defl_cnt  <= '0;
            alloc_err <= 1'b0;
            for (int p = 0; p < 4; p++) begin
                flit_q[p] <= '0;
            end
        end else begin
            valid_out <= nxt_valid;
            for (int p = 0; p < 4; p++) begin
                flit_q[p] <= nxt_flit[p];
            end
            if (stat_clr) begin
                defl_cnt  <= '0;
                alloc_err <= 1'b0;
            end else begin
                defl_cnt  <= defl_nxt;
                alloc_err <= alloc_err | err_evt;
            end
        end
    end

`ifdef BLESS_XBAR_PORT_STATS_EN
    logic [CNT_W-1:0] util_q [4];

    assign util_cnt_0 = util_q[0];
    assign util_cnt_1 = util_q[1];
    assign util_cnt_2 = util_q[2];
    assign util_cnt_3 = util_q[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                util_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (stat_clr) begin
                    util_q[p] <= '0;
                end else if (nxt_valid[p] && (util_q[p] != {CNT_W{1'b1}})) begin
                    util_q[p] <= util_q[p] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_bless_xbar_st3.sv
// tb/tb_bless_xbar_st3.sv - self-checking bench for bless_xbar_st3 against a behavioural port-allocation model

module tb_bless_xbar_st3;

    localparam int FLIT_W = 64;
    localparam int CNT_W  = 16;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [FLIT_W-1:0] t_flit [4];
    logic [3:0]        t_apv  [4];
    logic [3:0]        t_ppv  [4];
    logic [3:0]        valid_in = 4'b0000;
    logic              stat_clr = 1'b0;
    logic [FLIT_W-1:0] fo [4];
    logic [3:0]        valid_out;
    logic [CNT_W-1:0]  defl_cnt;
    logic              alloc_err;
`ifdef BLESS_XBAR_PORT_STATS_EN
    logic [CNT_W-1:0]  util [4];
`endif

    int checks = 0;
    int failures = 0;

    // Behavioural expectation state
    logic [3:0]        m_valid;
    logic [FLIT_W-1:0] m_flit [4];
    int                m_defl;
    logic              m_err;
    int                m_util [4];

    always #5 clk = ~clk;

    bless_xbar_st3 #(.FLIT_W(FLIT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .flit_in_0(t_flit[0]), .flit_in_1(t_flit[1]), .flit_in_2(t_flit[2]), .flit_in_3(t_flit[3]),
        .valid_in(valid_in),
        .apv_0(t_apv[0]), .apv_1(t_apv[1]), .apv_2(t_apv[2]), .apv_3(t_apv[3]),
        .ppv_0(t_ppv[0]), .ppv_1(t_ppv[1]), .ppv_2(t_ppv[2]), .ppv_3(t_ppv[3]),
        .stat_clr(stat_clr),
        .flit_out_0(fo[0]), .flit_out_1(fo[1]), .flit_out_2(fo[2]), .flit_out_3(fo[3]),
        .valid_out(valid_out), .defl_cnt(defl_cnt), .alloc_err(alloc_err)
`ifdef BLESS_XBAR_PORT_STATS_EN
        ,
        .util_cnt_0(util[0]), .util_cnt_1(util[1]), .util_cnt_2(util[2]), .util_cnt_3(util[3])
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m_valid = '0;
        m_defl  = 0;
        m_err   = 1'b0;
        for (int p = 0; p < 4; p++) begin
            m_flit[p] = '0;
            m_util[p] = 0;
        end
    endtask

    task automatic check_all();
        check("valid_out", 64'(valid_out), 64'(m_valid));
        for (int p = 0; p < 4; p++) begin
            check($sformatf("flit_out_%0d", p), fo[p], m_flit[p]);
        end
        check("defl_cnt", 64'(defl_cnt), 64'(m_defl));
        check("alloc_err", 64'(alloc_err), 64'(m_err));
`ifdef BLESS_XBAR_PORT_STATS_EN
        for (int p = 0; p < 4; p++) begin
            check($sformatf("util_cnt_%0d", p), 64'(util[p]), 64'(m_util[p]));
        end
`endif
    endtask

    // Evaluate the allocation rules for the inputs present at the coming edge,
    // advance one clock, then compare everything one time unit after the edge.
    task automatic tick();
        logic [3:0]        nv;
        logic [FLIT_W-1:0] nf [4];
        logic              ev;
        int                nd;
        int                port;
        nv = '0;
        ev = 1'b0;
        nd = 0;
        for (int p = 0; p < 4; p++) nf[p] = '0;
        for (int c = 0; c < 4; c++) begin
            if (valid_in[c]) begin
                if (t_apv[c] == 4'b0000) begin
                    ev = 1'b1;
                end else begin
                    port = 0;
                    while (!t_apv[c][port]) port++;
                    if ($countones(t_apv[c]) > 1) ev = 1'b1;
                    if (nv[port]) ev = 1'b1;
                    else begin
                        nv[port] = 1'b1;
                        nf[port] = t_flit[c];
                    end
                    if ((t_apv[c] & t_ppv[c]) == 4'b0000) nd++;
                end
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        for (int p = 0; p < 4; p++) m_flit[p] = nf[p];
        if (stat_clr) begin
            m_defl = 0;
            m_err  = 1'b0;
            for (int p = 0; p < 4; p++) m_util[p] = 0;
        end else begin
            m_defl = (m_defl + nd > CMAX) ? CMAX : m_defl + nd;
            m_err  = m_err | ev;
            for (int p = 0; p < 4; p++) begin
                if (nv[p] && m_util[p] < CMAX) m_util[p]++;
            end
        end
        check_all();
    endtask

    task automatic set_ch(input int c, input logic [3:0] a, input logic [3:0] pp, input logic [63:0] f);
        t_apv[c]  = a;
        t_ppv[c]  = pp;
        t_flit[c] = f;
    endtask

    initial begin
        int u1_before;
        int u3_before;
        for (int c = 0; c < 4; c++) set_ch(c, 4'b0000, 4'b0000, 64'h0);
        model_zero();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
        tick();

        // Full productive permutation
        set_ch(0, 4'b0001, 4'b0001, 64'hAAAA_0000_0000_000A);
        set_ch(1, 4'b0010, 4'b0010, 64'hBBBB_0000_0000_000B);
        set_ch(2, 4'b0100, 4'b0100, 64'hCCCC_0000_0000_000C);
        set_ch(3, 4'b1000, 4'b1000, 64'hDDDD_0000_0000_000D);
        valid_in = 4'b1111;
        tick();
        check("perm_valid", 64'(valid_out), 64'h0F);
        check("perm_flit3", fo[3], 64'hDDDD_0000_0000_000D);
        check("perm_err", 64'(alloc_err), 64'h0);

        // Asynchronous reset mid-cycle with traffic registered
        #3 reset = 1'b1;
        #1;
        model_zero();
        check_all();
        @(posedge clk);
        valid_in = 4'b0000;
        #3 reset = 1'b0;
        tick();
        tick();
        check("post_reset_valid", 64'(valid_out), 64'h0);

        // Deflection counting over three cycles
        set_ch(1, 4'b0100, 4'b0001, 64'h1111);
        set_ch(2, 4'b0001, 4'b0001, 64'h2222);
        valid_in = 4'b0110;
        repeat (3) tick();
        check("defl_three", 64'(defl_cnt), 64'd3);
        check("defl_valid", 64'(valid_out), 64'h5);

        // Conflict: ch0 and ch3 both on port 1
        set_ch(0, 4'b0010, 4'b0010, 64'h0C0C);
        set_ch(3, 4'b0010, 4'b0010, 64'h3C3C);
        valid_in = 4'b1001;
        tick();
        check("conf_flit1", fo[1], 64'h0C0C);
        check("conf_err", 64'(alloc_err), 64'h1);
        valid_in = 4'b0000;
        tick();
        check("conf_sticky", 64'(alloc_err), 64'h1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("conf_cleared", 64'(alloc_err), 64'h0);

        // Bad vectors: zero apv and multi-hot apv
        set_ch(2, 4'b0000, 4'b0001, 64'h2020);
        valid_in = 4'b0100;
        tick();
        check("zero_apv_err", 64'(alloc_err), 64'h1);
        check("zero_apv_valid", 64'(valid_out), 64'h0);
        stat_clr = 1'b1;
        valid_in = 4'b0000;
        tick();
        stat_clr = 1'b0;
        u1_before = m_util[1];
        u3_before = m_util[3];
        set_ch(1, 4'b1010, 4'b0010, 64'h1A1A);
        valid_in = 4'b0010;
        tick();
        check("multi_valid", 64'(valid_out), 64'h2);
        check("multi_flit1", fo[1], 64'h1A1A);
        check("multi_err", 64'(alloc_err), 64'h1);
`ifdef BLESS_XBAR_PORT_STATS_EN
        check("multi_util1", 64'(util[1]), 64'(u1_before + 1));
        check("multi_util3", 64'(util[3]), 64'(u3_before));
`endif

        // Saturation: preload to all-ones minus one, then four deflections
        stat_clr = 1'b1;
        valid_in = 4'b0000;
        tick();
        stat_clr = 1'b0;
        set_ch(0, 4'b0001, 4'b0000, 64'h10);
        set_ch(1, 4'b0010, 4'b0000, 64'h11);
        set_ch(2, 4'b0100, 4'b0000, 64'h12);
        set_ch(3, 4'b1000, 4'b0000, 64'h13);
        valid_in = 4'b1111;
        repeat ((CMAX - 1) / 4) tick();
        valid_in = 4'b0011;
        tick();
        check("preload", 64'(defl_cnt), 64'(CMAX - 1));
        valid_in = 4'b1111;
        tick();
        check("saturate", 64'(defl_cnt), 64'(CMAX));
        tick();
        check("saturate_hold", 64'(defl_cnt), 64'(CMAX));
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("clr_with_defl", 64'(defl_cnt), 64'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 4; c++) begin
                logic [3:0] a;
                if ($urandom_range(0, 7) < 5) a = 4'(1 << $urandom_range(0, 3));
                else a = 4'($urandom_range(0, 15));
                set_ch(c, a, 4'($urandom_range(0, 15)), {$urandom, $urandom});
            end
            valid_in = 4'($urandom_range(0, 15));
            stat_clr = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
